// File: rtl/voice_sequencer_mixer.sv
// Voice-slot sequencer plus per-voice gain mixer for the time-multiplexed synth pipeline.
// Optional peak-magnitude tracker enabled by defining MIX_PEAK_EN.
module voice_sequencer_mixer #(
    parameter int unsigned NUM_VOICES = 256,
    parameter int unsigned PHASES     = 4,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned MIX_W      = 24
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_enable,
    output logic                            o_ready,
    output logic [$clog2(NUM_VOICES)-1:0]   o_voice_index,
    output logic [$clog2(PHASES)-1:0]       o_phase,
    output logic                            o_slot_start,
    input  logic [SAMPLE_W-1:0]             i_sample,
    input  logic                            i_sample_valid,
    input  logic [$clog2(NUM_VOICES)-1:0]   i_sample_voice,
    input  logic                            i_gain_wr,
    input  logic [$clog2(NUM_VOICES)-1:0]   i_gain_voice,
    input  logic [7:0]                      i_gain,
    output logic [MIX_W-1:0]                o_mixed_sample,
    output logic                            o_mixed_valid,
    output logic                            o_clip,
    input  logic                            i_clip_clear,
    output logic [MIX_W-2:0]                o_peak
);
    localparam int unsigned VI_W   = $clog2(NUM_VOICES);
    localparam int unsigned PH_W   = $clog2(PHASES);
    localparam int unsigned TERM_W = SAMPLE_W + 9;
    localparam int unsigned SUM_W  = ((MIX_W > TERM_W) ? MIX_W : TERM_W) + 1;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-MIX_W+1){1'b0}}, {(MIX_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-MIX_W+1){1'b1}}, {(MIX_W-1){1'b0}}};
    localparam logic signed [MIX_W-1:0] MIX_MAX = {1'b0, {(MIX_W-1){1'b1}}};
    localparam logic signed [MIX_W-1:0] MIX_MIN = {1'b1, {(MIX_W-1){1'b0}}};

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [VI_W-1:0]   cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [VI_W-1:0]   index_q, index_d;
    logic              slot_q, slot_d;

    // Sequencer: gain-init sweep, then slot/phase counting gated by i_enable
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        phase_d = phase_q;
        index_d = index_q;
        slot_d  = 1'b0;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + VI_W'(1);
                if (cnt_q == VI_W'(NUM_VOICES - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                    index_d = '0;
                    slot_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_enable) begin
                    if (phase_q == PH_W'(PHASES - 1)) begin
                        phase_d = '0;
                        index_d = index_q + VI_W'(1);
                        slot_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            phase_q <= '0;
            index_q <= '0;
            slot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            phase_q <= phase_d;
            index_q <= index_d;
            slot_q  <= slot_d;
        end
    end

    // Gain RAM: init sweep owns the write port; reads return pre-write data
    logic [7:0]      gain_mem [NUM_VOICES];
    logic            gain_we;
    logic [VI_W-1:0] gain_waddr;
    logic [7:0]      gain_wdata;
    logic [7:0]      s1_gain_q;

    always_comb begin
        gain_we    = (state_q == ST_INIT) || i_gain_wr;
        gain_waddr = (state_q == ST_INIT) ? cnt_q : i_gain_voice;
        gain_wdata = (state_q == ST_INIT) ? 8'd128 : i_gain;
    end

    always_ff @(posedge i_clk) begin
        if (gain_we) gain_mem[gain_waddr] <= gain_wdata;
        s1_gain_q <= gain_mem[i_sample_voice];
    end

    logic signed [SAMPLE_W-1:0] s1_sample_q;
    logic                       s1_vld_q, s1_first_q, s1_last_q;
    logic signed [TERM_W-1:0]   term_q, term_d, prod;
    logic signed [8:0]          gain_ext;
    logic                       s2_vld_q, s2_first_q, s2_last_q;

    always_comb begin
        gain_ext = {1'b0, s1_gain_q};
        prod     = TERM_W'(s1_sample_q) * TERM_W'(gain_ext);
        term_d   = prod >>> 7;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_sample_q <= '0;
            s1_vld_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            term_q      <= '0;
            s2_vld_q    <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_last_q   <= 1'b0;
        end else begin
            s1_sample_q <= i_sample;
            s1_vld_q    <= i_sample_valid && (state_q != ST_INIT);
            s1_first_q  <= (i_sample_voice == VI_W'(0));
            s1_last_q   <= (i_sample_voice == VI_W'(NUM_VOICES - 1));
            term_q      <= term_d;
            s2_vld_q    <= s1_vld_q;
            s2_first_q  <= s1_first_q;
            s2_last_q   <= s1_last_q;
        end
    end

    logic signed [MIX_W-1:0] acc_q, acc_d, mixed_q, mixed_d, base, sat_val;
    logic signed [SUM_W-1:0] sum;
    logic                    ovf, mvalid_q, mvalid_d, clip_q, clip_d;

    // Saturating accumulate; voice 0 restarts the frame, last voice emits it
    always_comb begin
        base    = s2_first_q ? '0 : acc_q;
        sum     = SUM_W'(term_q) + SUM_W'(base);
        ovf     = 1'b0;
        sat_val = MIX_W'(sum);
        if (sum > SAT_MAX) begin
            sat_val = MIX_MAX;
            ovf     = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_val = MIX_MIN;
            ovf     = 1'b1;
        end
        acc_d    = acc_q;
        mixed_d  = mixed_q;
        mvalid_d = 1'b0;
        clip_d   = i_clip_clear ? 1'b0 : clip_q;
        if (s2_vld_q) begin
            if (ovf) clip_d = 1'b1;
            if (s2_last_q) begin
                mixed_d  = sat_val;
                mvalid_d = 1'b1;
                acc_d    = '0;
            end else begin
                acc_d = sat_val;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q    <= '0;
            mixed_q  <= '0;
            mvalid_q <= 1'b0;
            clip_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mixed_q  <= mixed_d;
            mvalid_q <= mvalid_d;
            clip_q   <= clip_d;
        end
    end

`ifdef MIX_PEAK_EN
    logic [MIX_W-2:0] peak_q, peak_d, mag;

    // Magnitude of the emitted sample; most-negative value clamps to max positive
    always_comb begin
        if (sat_val == MIX_MIN)   mag = {(MIX_W-1){1'b1}};
        else if (sat_val[MIX_W-1]) mag = (MIX_W-1)'(-sat_val);
        else                      mag = (MIX_W-1)'(sat_val);
        peak_d = i_clip_clear ? '0 : peak_q;
        if (s2_vld_q && s2_last_q && (i_clip_clear || (mag > peak_q))) peak_d = mag;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) peak_q <= '0;
        else         peak_q <= peak_d;
    end

    assign o_peak = peak_q;
`else
    assign o_peak = '0;
`endif

    assign o_ready        = ready_q;
    assign o_voice_index  = index_q;
    assign o_phase        = phase_q;
    assign o_slot_start   = slot_q;
    assign o_mixed_sample = mixed_q;
    assign o_mixed_valid  = mvalid_q;
    assign o_clip         = clip_q;

endmodule

// File: tb/tb_voice_sequencer_mixer.sv
// Directed bench for voice_sequencer_mixer: sequencer timing, gain scaling, saturation, resync, reset.
module tb_voice_sequencer_mixer;
    localparam int NV = 4;
    localparam int PH = 4;
    localparam int SW = 16;
    localparam int MW = 18;

    logic          i_clk;
    logic          i_reset;
    logic          i_enable;
    logic          o_ready;
    logic [1:0]    o_voice_index;
    logic [1:0]    o_phase;
    logic          o_slot_start;
    logic [SW-1:0] i_sample;
    logic          i_sample_valid;
    logic [1:0]    i_sample_voice;
    logic          i_gain_wr;
    logic [1:0]    i_gain_voice;
    logic [7:0]    i_gain;
    logic [MW-1:0] o_mixed_sample;
    logic          o_mixed_valid;
    logic          o_clip;
    logic          i_clip_clear;
    logic [MW-2:0] o_peak;

    int n_tests = 0;
    int n_fail  = 0;

    voice_sequencer_mixer #(
        .NUM_VOICES(NV), .PHASES(PH), .SAMPLE_W(SW), .MIX_W(MW)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .o_ready(o_ready),
        .o_voice_index(o_voice_index), .o_phase(o_phase), .o_slot_start(o_slot_start),
        .i_sample(i_sample), .i_sample_valid(i_sample_valid), .i_sample_voice(i_sample_voice),
        .i_gain_wr(i_gain_wr), .i_gain_voice(i_gain_voice), .i_gain(i_gain),
        .o_mixed_sample(o_mixed_sample), .o_mixed_valid(o_mixed_valid), .o_clip(o_clip),
        .i_clip_clear(i_clip_clear), .o_peak(o_peak)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic put(input int v, input int s);
        i_sample_voice = 2'(v);
        i_sample       = 16'(s);
        i_sample_valid = 1'b1;
        @(negedge i_clk);
        i_sample_valid = 1'b0;
    endtask

    task automatic set_gain(input int v, input int g);
        i_gain_wr    = 1'b1;
        i_gain_voice = 2'(v);
        i_gain       = 8'(g);
        @(negedge i_clk);
        i_gain_wr = 1'b0;
    endtask

    // Called right after the last put; strobe expected two negedges later
    task automatic expect_frame(input string tag, input int exp);
        int lat;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge i_clk);
            if (o_mixed_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, lat, 2);
        if (lat > 0) check(tag, $signed(o_mixed_sample), exp);
    endtask

    initial begin
        int strobes;
        i_reset = 1'b1; i_enable = 1'b1; i_sample = '0; i_sample_valid = 1'b0;
        i_sample_voice = '0; i_gain_wr = 1'b0; i_gain_voice = '0; i_gain = '0;
        i_clip_clear = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_ready", o_ready, 0);
        check("rst_index", o_voice_index, 0);
        check("rst_slot", o_slot_start, 0);
        check("rst_mixed", $signed(o_mixed_sample), 0);
        check("rst_valid", o_mixed_valid, 0);
        check("rst_clip", o_clip, 0);
        i_reset = 1'b0;

        // Init sweep then free-running slot counter
        for (int i = 0; i < 4; i++) begin
            check("init_ready", o_ready, 0);
            @(negedge i_clk);
        end
        check("ready", o_ready, 1);
        for (int i = 0; i <= 16; i++) begin
            @(negedge i_clk);
            check("seq_phase", o_phase, i % 4);
            check("seq_index", o_voice_index, (i / 4) % 4);
            check("seq_slot", o_slot_start, (i % 4) == 0);
        end
        i_enable = 1'b0;
        repeat (2) @(negedge i_clk);
        check("frz_phase", o_phase, 0);
        check("frz_index", o_voice_index, 0);
        check("frz_slot", o_slot_start, 0);
        i_enable = 1'b1;

        // Unity gain frame
        put(0, 100); put(1, 200); put(2, -50); put(3, 25);
        expect_frame("unity", 275);
`ifdef MIX_PEAK_EN
        check("peak", o_peak, 275);
`else
        check("peak_tied", o_peak, 0);
`endif
        @(negedge i_clk);
        check("strobe_width", o_mixed_valid, 0);
        check("hold", $signed(o_mixed_sample), 275);

        // Half gain with floor rounding
        set_gain(1, 64);
        put(0, 0); put(1, 201); put(2, 0); put(3, 0);
        expect_frame("half_pos", 100);
        put(0, 0); put(1, -201); put(2, 0); put(3, 0);
        expect_frame("half_neg", -101);

        // Max gain saturation both directions
        for (int v = 0; v < 4; v++) set_gain(v, 255);
        for (int v = 0; v < 4; v++) put(v, 32767);
        expect_frame("sat_pos", 131071);
        check("clip_set", o_clip, 1);
        for (int v = 0; v < 4; v++) put(v, -32768);
        expect_frame("sat_neg", -131072);

        // Clear held through a saturating frame: set wins, then clear takes effect
        i_clip_clear = 1'b1;
        for (int v = 0; v < 4; v++) put(v, 32767);
        expect_frame("sat_clr", 131071);
        check("clip_vs_clear", o_clip, 1);
        @(negedge i_clk);
        check("clip_cleared", o_clip, 0);
        i_clip_clear = 1'b0;

        // Read-first gain RAM
        for (int v = 0; v < 4; v++) set_gain(v, 128);
        i_gain_wr = 1'b1; i_gain_voice = 2'd0; i_gain = 8'd0;
        put(0, 100);
        i_gain_wr = 1'b0;
        put(1, 0); put(2, 0); put(3, 0);
        expect_frame("rd_first_old", 100);
        put(0, 100); put(1, 0); put(2, 0); put(3, 0);
        expect_frame("rd_first_new", 0);
        set_gain(0, 128);

        // Frame resync on voice 0, then a partial frame without voice 0
        put(0, 10); put(1, 10);
        put(0, 1); put(1, 1); put(2, 1); put(3, 1);
        expect_frame("resync", 4);
        put(2, 7); put(3, 5);
        expect_frame("partial", 12);

        // Mid-frame reset restarts the sweep and restores unity gain
        set_gain(2, 64);
        put(0, 50); put(1, 60);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        check("mid_rst_mixed", $signed(o_mixed_sample), 0);
        check("mid_rst_ready", o_ready, 0);
        check("mid_rst_valid", o_mixed_valid, 0);
        i_reset = 1'b0;
        put(3, 999);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_ready) break;
            if (o_mixed_valid) strobes++;
            @(negedge i_clk);
        end
        check("init_drop", strobes, 0);
        check("reready", o_ready, 1);
        put(0, 1); put(1, 2); put(2, 3); put(3, 4);
        expect_frame("post_rst", 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
